// File: rtl/seq_mac_explorer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mac_explorer_pkg
// Description : Operation encodings and FSM state type for seq_mac_explorer.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mac_explorer_pkg;

    localparam logic [1:0] MODE_MULT  = 2'b00;
    localparam logic [1:0] MODE_ADD   = 2'b01;
    localparam logic [1:0] MODE_MAC   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mac_explorer_operand_shifter.sv
`default_nettype none
// ============================================================================
// Module      : operand_shifter
// Description : WIDTH-bit MSB-first serial-in shift register with enable.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_shifter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[WIDTH-2:0], i_sin};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_mac_explorer.sv
`default_nettype none
// ============================================================================
// Module      : seq_mac_explorer
// Description : Serial-loaded operands feeding an iterative multiply / add /
//               multiply-accumulate unit with byte-addressable result.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mac_explorer
    import seq_mac_explorer_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int ACC_WIDTH = 2*WIDTH+4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       sin_a,
    input  logic       sin_b,
    input  logic       shift,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] byte_sel,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t               r_state;
    logic [1:0]           r_mode;
    logic [WIDTH-1:0]     r_wa;
    logic [WIDTH-1:0]     r_wb;
    logic [2*WIDTH-1:0]   r_prod;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [31:0]          r_result;
    logic                 r_done;
    logic                 r_ovf;

    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic                 w_shift_en;
    logic [WIDTH:0]       w_upper_sum;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic [WIDTH:0]       w_add;
    logic [ACC_WIDTH:0]   w_mac_sum;

    assign busy       = (r_state != ST_IDLE);
    assign w_shift_en = ena & shift & ~busy;

    operand_shifter #(.WIDTH(WIDTH)) u_shift_a (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_shift_en),
        .i_sin (sin_a),
        .o_q   (w_a)
    );

    operand_shifter #(.WIDTH(WIDTH)) u_shift_b (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_shift_en),
        .i_sin (sin_b),
        .o_q   (w_b)
    );

    // Product register holds {partial sum, remaining multiplier bits}; each
    // step conditionally adds A into the top half and shifts right by one.
    assign w_upper_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_wa} : '0);
    assign w_prod_next = {w_upper_sum, r_prod[WIDTH-1:1]};
    assign w_add       = {1'b0, r_wa} + {1'b0, r_wb};
    assign w_mac_sum   = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_prod);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_MULT;
            r_wa     <= '0;
            r_wb     <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_wa    <= w_a;
                        r_wb    <= w_b;
                        r_prod  <= {{WIDTH{1'b0}}, w_b};
                        r_cnt   <= '0;
                        r_state <= (mode == MODE_MULT || mode == MODE_MAC) ? ST_MUL : ST_WRITE;
                    end
                end
                ST_MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(WIDTH-1)) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    case (r_mode)
                        MODE_MULT: r_result <= 32'(r_prod);
                        MODE_ADD:  r_result <= 32'(w_add);
                        MODE_MAC: begin
                            r_acc    <= w_mac_sum[ACC_WIDTH-1:0];
                            r_result <= 32'(w_mac_sum[ACC_WIDTH-1:0]);
                            if (w_mac_sum[ACC_WIDTH]) begin
                                r_ovf <= 1'b1;
                            end
                        end
                        default: begin
                            r_acc    <= '0;
                            r_result <= '0;
                            r_ovf    <= 1'b0;
                        end
                    endcase
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout     = r_result[{byte_sel, 3'b000} +: 8];
    assign done     = r_done;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_mac_explorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mac_explorer
// Description : Self-checking bench for seq_mac_explorer (WIDTH=6, ACC=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mac_explorer;

    localparam int W   = 6;
    localparam int ACC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b1;
    logic       sin_a = 1'b0;
    logic       sin_b = 1'b0;
    logic       shift = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] byte_sel = 2'b00;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_a = 0;
    int m_b = 0;
    int m_acc = 0;
    int m_ovf = 0;
    int m_result = 0;

    seq_mac_explorer #(.WIDTH(W), .ACC_WIDTH(ACC)) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .sin_a    (sin_a),
        .sin_b    (sin_b),
        .shift    (shift),
        .start    (start),
        .mode     (mode),
        .byte_sel (byte_sel),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_in(input int a, input int b);
        for (int i = W-1; i >= 0; i--) begin
            sin_a = a[i];
            sin_b = b[i];
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        m_a = a;
        m_b = b;
    endtask

    task automatic read_result(output logic [31:0] r);
        for (int s = 0; s < 4; s++) begin
            byte_sel = 2'(s);
            #1;
            r[8*s +: 8] = dout;
        end
        byte_sel = 2'b00;
    endtask

    // Applies the arithmetic rules of each operation to the model.
    task automatic model_op(input int m);
        int sum;
        case (m)
            0: m_result = m_a * m_b;
            1: m_result = m_a + m_b;
            2: begin
                sum = m_acc + m_a * m_b;
                if (sum >= (1 << ACC)) m_ovf = 1;
                m_acc = sum % (1 << ACC);
                m_result = m_acc;
            end
            default: begin
                m_acc = 0;
                m_result = 0;
                m_ovf = 0;
            end
        endcase
    endtask

    task automatic run_op(input int m, output int lat);
        mode = 2'(m);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        model_op(m);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        ena = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ena = 1'b1;
        m_a = 0; m_b = 0; m_acc = 0; m_ovf = 0; m_result = 0;
        read_result(r);
        checks++;
        if ({busy, done, overflow} !== 3'b000 || r !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: busy/done/ovf=%b result=%h, required 000 / 0", {busy, done, overflow}, r);
        end
    endtask

    task automatic test_mult_directed();
        int lat;
        logic [31:0] r;
        shift_in(45, 38);
        run_op(0, lat);
        read_result(r);
        checks++;
        if (lat != W+1) begin
            failures++;
            $display("FAIL mult_latency: got %0d required %0d", lat, W+1);
        end
        checks++;
        if (r !== 32'h0000_06AE) begin
            failures++;
            $display("FAIL mult_45x38: got %h required 000006ae", r);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [31:0] r;
        shift_in(63, 63);
        run_op(1, lat);
        read_result(r);
        checks++;
        if (lat != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_latency: got lat=%0d busy=%b required lat=1 busy=0", lat, busy);
        end
        checks++;
        if (r !== 32'h0000_007E) begin
            failures++;
            $display("FAIL add_63p63: got %h required 0000007e", r);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL add_after_done: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_mac_overflow();
        int lat;
        logic [31:0] r;
        run_op(3, lat);
        for (int i = 0; i < 16; i++) run_op(2, lat);
        read_result(r);
        checks++;
        if (r !== 32'h0000_F810 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL mac_16: got %h ovf=%b required 0000f810 ovf=0", r, overflow);
        end
        run_op(2, lat);
        read_result(r);
        checks++;
        if (r !== 32'h0000_0791 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL mac_17: got %h ovf=%b required 00000791 ovf=1", r, overflow);
        end
        run_op(2, lat);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL mac_sticky: ovf=%b required 1", overflow);
        end
        run_op(3, lat);
        read_result(r);
        checks++;
        if (r !== 32'd0 || overflow !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL clear: got %h ovf=%b lat=%0d required 0 0 1", r, overflow, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        int seen_done;
        shift_in(int'($urandom_range(1, 63)), int'($urandom_range(1, 63)));
        mode = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_a = 0; m_b = 0; m_acc = 0; m_ovf = 0; m_result = 0;
        read_result(r);
        checks++;
        if (busy !== 1'b0 || r !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort_state: busy=%b result=%h required 0 0", busy, r);
        end
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) seen_done = 1;
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL reset_abort_done: done pulse seen=%0d required 0", seen_done);
        end
    endtask

    task automatic test_busy_ignore();
        int a, b, lat;
        logic [31:0] r;
        a = int'($urandom_range(0, 63));
        b = int'($urandom_range(0, 63));
        shift_in(a, b);
        mode = 2'b00;
        start = 1'b1;
        tick();
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            mode = 2'b11;
            start = 1'b1;
            shift = 1'b1;
            sin_a = 1'($urandom);
            sin_b = 1'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
        shift = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        model_op(0);
        read_result(r);
        checks++;
        if (lat != W+1 || r !== 32'(m_result)) begin
            failures++;
            $display("FAIL busy_ignore_mult: lat=%0d got %h required lat=%0d %h", lat, r, W+1, 32'(m_result));
        end
        run_op(1, lat);
        read_result(r);
        checks++;
        if (r !== 32'(m_result)) begin
            failures++;
            $display("FAIL busy_ignore_operands: got %h required %h", r, 32'(m_result));
        end
    endtask

    task automatic test_ena_stall();
        int lat, bad;
        logic [31:0] r;
        shift_in(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        mode = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        lat = 2;
        ena = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            lat++;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        ena = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        model_op(0);
        checks++;
        if (lat != W+1+5 || bad != 0) begin
            failures++;
            $display("FAIL ena_stall_latency: lat=%0d bad=%0d required %0d 0", lat, bad, W+6);
        end
        read_result(r);
        checks++;
        if (r !== 32'(m_result)) begin
            failures++;
            $display("FAIL ena_stall_result: got %h required %h", r, 32'(m_result));
        end
        ena = 1'b0;
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ena_done_hold: done=%b required 1", done);
        end
        ena = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL ena_done_release: done=%b required 0", done);
        end
    endtask

    task automatic test_random();
        int m, lat, exp_lat;
        logic [31:0] r;
        for (int n = 0; n < 30; n++) begin
            shift_in(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            m = int'($urandom_range(0, 3));
            exp_lat = (m == 0 || m == 2) ? W+1 : 1;
            run_op(m, lat);
            read_result(r);
            checks++;
            if (lat != exp_lat || r !== 32'(m_result) || overflow !== 1'(m_ovf)) begin
                failures++;
                $display("FAIL random_op%0d mode=%0d: lat=%0d res=%h ovf=%b required lat=%0d res=%h ovf=%0d",
                         n, m, lat, r, overflow, exp_lat, 32'(m_result), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_add();
        test_mac_overflow();
        test_reset_abort();
        test_busy_ignore();
        test_ena_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
